// File: rtl/bcd_seq.sv
// bcd_seq: sequential binary-to-BCD converter using the double-dabble method.
// The converter runs one shift step per clock and uses valid/ready handshakes
// on both the input and the output side.
//
// Ports:
//   clk        clock, rising edge active
//   rst        asynchronous active-high reset
//   in_valid   num holds a value to convert
//   in_ready   block is IDLE and can accept a value
//   num        unsigned binary value, WIDTH bits
//   out_valid  bcd/overflow hold a finished result (DONE state)
//   out_ready  consumer takes the result
//   bcd        packed BCD result; digit k is at bits [4k+3:4k]
//   overflow   value did not fit in DIGITS digits (bcd is num mod 10^DIGITS)
module bcd_seq #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      num,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned SW = BW + WIDTH;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [BW-1:0]    adj_c;
   logic [SW-1:0]    cat_c;

   // Add-3 correction on every digit that is 5 or more, then the joint shift.
   always_comb begin
      logic [3:0] dig;
      adj_c = bcd_q;
      dig   = 4'd0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         dig = bcd_q[4*k +: 4];
         adj_c[4*k +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
      end
      cat_c = {adj_c, bin_q} << 1;
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               bin_d   = num;
               bcd_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = CW'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, bin_d} = cat_c;
            // The top bit of the corrected digits is the one shifted out.
            ovf_d = ovf_q | adj_c[BW-1];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign bcd       = bcd_q;
   assign overflow  = ovf_q;

endmodule

// File: doc/bcd_seq.md
BCD_SEQ -- requirements
Module: bcd_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: binary input width in bits (WIDTH >= 1).
REQ-002 SHALL provide parameter DIGITS, default 3: number of BCD output digits (DIGITS >= 1).
REQ-003 SHALL have one clock and an asynchronous, active-high reset; there are no other clocks.
REQ-004 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port in_valid, input, 1: num holds a value to convert.
REQ-007 Port in_ready, output, 1: block can accept a value.
REQ-008 Port num, input, WIDTH: unsigned binary value.
REQ-009 Port out_valid, output, 1: bcd and overflow hold a finished result.
REQ-010 Port out_ready, input, 1: consumer takes the result.
REQ-011 Port bcd, output, 4*DIGITS: packed BCD result; digit k (10^k place) occupies bits [4k+3:4k].
REQ-012 Port overflow, output, 1: value did not fit in DIGITS digits.

Function
REQ-013 SHALL implement three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE: in_ready=1 and out_valid=0; in other states: in_ready=0.
REQ-015 Accept: a rising edge with in_valid=1 and in_ready=1 SHALL capture num into an internal shift register, clear the digit register and overflow, set the bit counter to WIDTH, and go to SHIFT.
REQ-016 num SHALL be sampled only at accept; later changes to num SHALL NOT affect the result.
REQ-017 Each edge in SHIFT SHALL perform one double-dabble step:
- each of the DIGITS digits >= 5 gets +3 (4-bit result);
- then {digits, binary} shifts left by 1;
- the counter decrements.
REQ-018 A 1 bit shifted out of the top digit SHALL set overflow, which stays set until the next accept.
REQ-019 The edge on which the counter reaches 0 SHALL go to DONE; out_valid=1 is first seen exactly WIDTH clock edges after the accept edge.
REQ-020 In DONE: out_valid=1, and bcd and overflow SHALL be held stable while out_ready=0 (unbounded backpressure).
REQ-021 An edge in DONE with out_ready=1 SHALL return the block to IDLE; a new accept is possible no earlier than the following edge.
REQ-022 bcd and overflow SHALL keep the last result in IDLE and change only during a conversion.
REQ-023 When overflow=1, bcd SHALL equal num mod 10^DIGITS.
REQ-024 in_valid in SHIFT or DONE SHALL be ignored; out_ready outside DONE SHALL be ignored.
REQ-025 The counter SHALL be clog2(WIDTH+1) bits wide; WIDTH=1 SHALL work (a single SHIFT cycle).

Reset
REQ-026 While rst=1, regardless of clk:
- state = IDLE, in_ready=1, out_valid=0, bcd=0, overflow=0;
- shift register and counter cleared.
REQ-027 rst asserted in SHIFT or DONE SHALL abort the conversion with no output; the first accept after release SHALL convert correctly.

Verification
REQ-028 WIDTH=8, DIGITS=3, num=255 accepted -> out_valid after 8 edges, bcd=12'h255, overflow=0.
REQ-029 WIDTH=8, DIGITS=3, num=0 -> bcd=12'h000, overflow=0; num=99 -> bcd=12'h099.
REQ-030 WIDTH=16, DIGITS=5, num=65535 -> bcd=20'h65535 after 16 edges; num=10000 -> bcd=20'h10000.
REQ-031 WIDTH=8, DIGITS=2, num=100 -> overflow=1, bcd=8'h00; then num=42 -> overflow=0, bcd=8'h42.
REQ-032 num=37, out_ready=0 for 5 cycles after out_valid, with in_valid=1 and num toggled -> bcd=12'h037 stable, in_ready=0; with out_ready=1, IDLE on the next edge.
REQ-033 rst pulsed 4 edges after accepting num=200 -> out_valid=0, in_ready=1 immediately; a following accept of num=7 -> bcd=12'h007.
